// File: rtl/ex_muldiv.sv
// ex_muldiv: HI/LO multiply/divide unit for the EX stage.
// Multiply completes after MUL_LATENCY busy cycles; divide is a radix-2
// restoring divider on operand magnitudes followed by one sign-fixup cycle.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish divides by zero, or
// with |dividend| < |divisor|, after a single busy cycle.
module ex_muldiv #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  input  logic             ReadHiLo,
  input  logic             Flush,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             ALUStall,
  output logic             Done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 9);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               in_signed;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [PW-1:0]      ext_a, ext_b, prod;
  logic [WIDTH:0]     rem_sh, diff;
  logic               q_neg, r_neg;

  // Operand magnitudes for the op being issued (Op[0]=0 selects signed forms)
  always_comb begin
    in_signed = ~Op[0];
    rs_mag    = (in_signed && RsData[WIDTH-1]) ? WIDTH'(-RsData) : RsData;
    rt_mag    = (in_signed && RtData[WIDTH-1]) ? WIDTH'(-RtData) : RtData;
  end

  // Full-width product; low 2*WIDTH bits of the extended product are exact
  always_comb begin
    ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = ext_a * ext_b;
  end

  // One restoring-divide step plus result sign selection
  always_comb begin
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    q_neg  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg  = sgn_q & a_q[WIDTH-1];
  end

  // Next-state, datapath and result writeback
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Start && !Flush) begin
          unique case (Op)
            3'd0, 3'd1: begin
              a_d     = RsData;
              b_d     = RtData;
              sgn_d   = in_signed;
              cnt_d   = CNT_W'(MUL_LATENCY - 1);
              state_d = S_MUL;
            end
            3'd2, 3'd3: begin
              a_d     = RsData;
              b_d     = RtData;
              sgn_d   = in_signed;
              quo_d   = rs_mag;
              rem_d   = '0;
              dvs_d   = rt_mag;
              cnt_d   = '0;
              state_d = S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
              // Quotient is trivially zero (or the div-by-zero pattern): skip to fixup
              if ((RtData == '0) || (rs_mag < rt_mag)) begin
                quo_d = '0;
                rem_d = rs_mag;
                cnt_d = CNT_W'(WIDTH);
              end
`endif
            end
            3'd4:    hi_d = RsData;
            3'd5:    lo_d = RsData;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          hi_d    = prod[PW-1:WIDTH];
          lo_d    = prod[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DIV: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(WIDTH)) begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = q_neg ? WIDTH'(-quo_q) : quo_q;
            hi_d = r_neg ? WIDTH'(-rem_q) : rem_q;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (!diff[WIDTH]) begin
            rem_d = diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  // Output drive; ALUStall is the only combinational output
  always_comb begin
    Hi       = hi_q;
    Lo       = lo_q;
    Done     = done_q;
    Busy     = (state_q != S_IDLE);
    ALUStall = Busy & (Start | ReadHiLo);
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv at WIDTH=32, MUL_LATENCY=4.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        ReadHiLo;
  logic        Flush;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        Busy;
  logic        ALUStall;
  logic        Done;

  int n_tests = 0;
  int n_fail  = 0;
  int cycles;
  logic done_seen;

  ex_muldiv #(.WIDTH(32), .MUL_LATENCY(4)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .RsData(RsData),
    .RtData(RtData), .ReadHiLo(ReadHiLo), .Flush(Flush), .Hi(Hi), .Lo(Lo),
    .Busy(Busy), .ALUStall(ALUStall), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, then step until Busy drops (bounded); leaves the bench in the
  // first non-busy cycle with inputs idle
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        output int busy_cycles, output logic done_at_end);
    Start = 1'b1; Op = op; RsData = rs; RtData = rt;
    step();
    Start = 1'b0;
    busy_cycles = 0;
    while (Busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      step();
    end
    done_at_end = Done;
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; Op = 3'd0; RsData = '0; RtData = '0;
    ReadHiLo = 1'b0; Flush = 1'b0;
    step();
    step();
    chk("reset_hi", 64'(Hi), 64'h0);
    chk("reset_lo", 64'(Lo), 64'h0);
    chk("reset_busy", 64'(Busy), 64'h0);
    chk("reset_done", 64'(Done), 64'h0);
    rst = 1'b0;

    // MULT -2 * 3
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, cycles, done_seen);
    chk("mult_cycles", 64'(cycles), 64'd4);
    chk("mult_done", 64'(done_seen), 64'h1);
    chk("mult_hi", 64'(Hi), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(Lo), 64'hFFFF_FFFA);
    step();
    chk("done_one_pulse", 64'(Done), 64'h0);

    // MULTU max * max
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cycles, done_seen);
    chk("multu_hi", 64'(Hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(Lo), 64'h1);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, cycles, done_seen);
    chk("div_cycles", 64'(cycles), 64'd33);
    chk("div_done", 64'(done_seen), 64'h1);
    chk("div_lo", 64'(Lo), 64'hFFFF_FFFD);
    chk("div_hi", 64'(Hi), 64'hFFFF_FFFF);

    // DIVU 7 / 0
    run_op(3'd3, 32'd7, 32'd0, cycles, done_seen);
`ifdef MULDIV_EARLY_OUT_EN
    chk("divu0_cycles", 64'(cycles), 64'd1);
`else
    chk("divu0_cycles", 64'(cycles), 64'd33);
`endif
    chk("divu0_lo", 64'(Lo), 64'hFFFF_FFFF);
    chk("divu0_hi", 64'(Hi), 64'd7);

    // DIV most-negative / -1
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cycles, done_seen);
    chk("divovf_lo", 64'(Lo), 64'h8000_0000);
    chk("divovf_hi", 64'(Hi), 64'h0);

    // DIV 7 / -2
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, cycles, done_seen);
    chk("divneg_lo", 64'(Lo), 64'hFFFF_FFFD);
    chk("divneg_hi", 64'(Hi), 64'h1);

    // DIV -8 / 0 signed divide-by-zero
    run_op(3'd2, 32'hFFFF_FFF8, 32'd0, cycles, done_seen);
    chk("div0s_lo", 64'(Lo), 64'hFFFF_FFFF);
    chk("div0s_hi", 64'(Hi), 64'hFFFF_FFF8);

    // MTHI / MTLO
    Start = 1'b1; Op = 3'd4; RsData = 32'h11;
    step();
    chk("mthi_hi", 64'(Hi), 64'h11);
    chk("mthi_busy", 64'(Busy), 64'h0);
    chk("mthi_done", 64'(Done), 64'h0);
    Op = 3'd5; RsData = 32'h22;
    step();
    chk("mtlo_lo", 64'(Lo), 64'h22);
    chk("mtlo_hi_kept", 64'(Hi), 64'h11);

    // Reserved op
    Op = 3'd6; RsData = 32'h99; RtData = 32'h5;
    step();
    chk("op6_hi", 64'(Hi), 64'h11);
    chk("op6_lo", 64'(Lo), 64'h22);
    chk("op6_busy", 64'(Busy), 64'h0);

    // Flush and Start together: nothing accepted
    Op = 3'd4; RsData = 32'h77; Flush = 1'b1;
    step();
    chk("flush_mt_hi", 64'(Hi), 64'h11);
    Op = 3'd2; RsData = 32'd9; RtData = 32'd3;
    step();
    chk("flush_div_busy", 64'(Busy), 64'h0);
    Start = 1'b0; Flush = 1'b0;

    // Flush at cycle 10 of a DIV
    Start = 1'b1; Op = 3'd2; RsData = 32'd100; RtData = 32'd3;
    step();
    Start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("flush10_busy_before", 64'(Busy), 64'h1);
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush10_busy", 64'(Busy), 64'h0);
    chk("flush10_done", 64'(Done), 64'h0);
    chk("flush10_hi", 64'(Hi), 64'h11);
    chk("flush10_lo", 64'(Lo), 64'h22);
    step();
    chk("flush10_done_late", 64'(Done), 64'h0);

    // ReadHiLo stall during DIVU 100/7 and MTHI attempt while busy
    Start = 1'b1; Op = 3'd3; RsData = 32'd100; RtData = 32'd7;
    step();
    Start = 1'b0;
    step();
    ReadHiLo = 1'b1;
    #1;
    chk("stall_high", 64'(ALUStall), 64'h1);
    Start = 1'b1; Op = 3'd4; RsData = 32'hDEAD;
    step();
    Start = 1'b0;
    chk("mthi_busy_hi", 64'(Hi), 64'h11);
    cycles = 0;
    while (Busy === 1'b1 && cycles < 200) begin
      cycles++;
      step();
    end
    chk("stall_done", 64'(Done), 64'h1);
    chk("stall_low_on_done", 64'(ALUStall), 64'h0);
    chk("divu_lo", 64'(Lo), 64'd14);
    chk("divu_hi", 64'(Hi), 64'd2);
    ReadHiLo = 1'b0;

    // Back-to-back: start issued in the Done cycle
    run_op(3'd0, 32'd5, 32'd6, cycles, done_seen);
    chk("b2b_first_done", 64'(done_seen), 64'h1);
    chk("b2b_first_lo", 64'(Lo), 64'd30);
    run_op(3'd1, 32'd2, 32'd3, cycles, done_seen);
    chk("b2b_second_cycles", 64'(cycles), 64'd4);
    chk("b2b_second_lo", 64'(Lo), 64'd6);
    chk("b2b_second_hi", 64'(Hi), 64'd0);

    // Reset during a MULT
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2, cycles, done_seen);
    Start = 1'b1; Op = 3'd0; RsData = 32'd3; RtData = 32'd4;
    step();
    Start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mul_hi", 64'(Hi), 64'h0);
    chk("rst_mul_lo", 64'(Lo), 64'h0);
    chk("rst_mul_busy", 64'(Busy), 64'h0);
    chk("rst_mul_done", 64'(Done), 64'h0);
    step();
    chk("rst_mul_done_late", 64'(Done), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
